// File: rtl/priodec_pkg.sv
// Shared types for the priority decoder stream: default widths,
// FSM state encoding and the buffered {none, code} entry.
package priodec_pkg;

    localparam int CODE_W_DEF = 3;
    localparam int OUT_W_DEF  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic                  none;
        logic [CODE_W_DEF-1:0] code;
    } entry_t;

endpackage

// File: rtl/priodec_if.sv
// Encoded-request stream in, one-hot strobe bus out.
interface priodec_if
    import priodec_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              in_none;
    logic [OUT_W-1:0]  out_onehot;
    logic              out_valid;

    modport master (
        output in_valid, in_code, in_none,
        input  in_ready, out_onehot, out_valid
    );

    modport slave (
        input  in_valid, in_code, in_none,
        output in_ready, out_onehot, out_valid
    );

endinterface

// File: rtl/priodec_fifo.sv
// Synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module priodec_fifo #(
    parameter int  WIDTH = 4,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even if a pop frees a slot on the same edge.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/priority_decoder_stream.sv
// Buffered 3-to-8 decoder emitting held one-hot strobes.
// Optional PRIODEC_EVENT_COUNT_EN adds a saturating count of decoded pops.
module priority_decoder_stream
    import priodec_pkg::*;
#(
    parameter int CODE_W      = CODE_W_DEF,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    priodec_if.slave    bus,
    output logic        busy
`ifdef PRIODEC_EVENT_COUNT_EN
    ,
    output logic [15:0] event_cnt
`endif
);

    localparam int ENTRY_W = CODE_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int HC_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    entry_t           wr_entry;
    entry_t           head;
    logic             full;
    logic             empty;
    logic             pop;
    logic [CNT_W-1:0] count;

    state_e           state_q, state_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [OUT_W-1:0] onehot_q, onehot_d;
    logic             valid_q, valid_d;

    always_comb begin
        wr_entry      = '0;
        wr_entry.none = bus.in_none;
        wr_entry.code = bus.in_code;
    end

    priodec_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A finished hold reloads straight from the FIFO so strobes abut.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: pop = !empty;
            HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    onehot_d = '0;
                    valid_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            onehot_d = head.none ? '0 : (OUT_W'(1) << head.code);
            valid_d  = 1'b1;
            hold_d   = HC_W'(HOLD_CYCLES - 1);
            state_d  = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

`ifdef PRIODEC_EVENT_COUNT_EN
    logic [15:0] evt_q, evt_d;

    always_comb begin
        evt_d = evt_q;
        if (pop && !head.none && evt_q != 16'hFFFF) begin
            evt_d = evt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign event_cnt = evt_q;
`endif

    assign bus.in_ready   = !full;
    assign bus.out_onehot = onehot_q;
    assign bus.out_valid  = valid_q;
    assign busy           = (count != '0) || (state_q == HOLD);

endmodule

// File: tb/tb_priority_decoder_stream.sv
// Directed bench for priority_decoder_stream with a queue-based reference.
module tb_priority_decoder_stream;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    bit   full_seen = 1'b0;
    logic [8:0] trace[$];

    priodec_if #(.CODE_W(3), .OUT_W(8)) bus ();

`ifdef PRIODEC_EVENT_COUNT_EN
    logic [15:0] event_cnt;
`endif

    priority_decoder_stream #(
        .CODE_W      (3),
        .OUT_W       (8),
        .FIFO_DEPTH  (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy)
`ifdef PRIODEC_EVENT_COUNT_EN
        ,
        .event_cnt (event_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference: queue of pending entries plus cycles left on the strobe.
    logic [3:0] mq[$];
    int         rem = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_onehot = 8'h00;
    int         m_evt = 0;

    always @(posedge clk) begin : model
        bit         acc;
        logic [3:0] e;
        if (rst) begin
            mq.delete();
            rem      = 0;
            m_valid  = 1'b0;
            m_onehot = 8'h00;
            m_evt    = 0;
        end else begin
            acc = bus.in_valid && (mq.size() < DEPTH);
            if (rem > 1) begin
                rem--;
            end else if (mq.size() > 0) begin
                e        = mq.pop_front();
                m_valid  = 1'b1;
                m_onehot = e[3] ? 8'h00 : 8'(1 << e[2:0]);
                rem      = HOLD;
                if (!e[3] && m_evt < 65535) m_evt++;
            end else begin
                m_valid  = 1'b0;
                m_onehot = 8'h00;
                rem      = 0;
            end
            if (acc) mq.push_back({bus.in_none, bus.in_code});
        end
    end

    always @(negedge clk) begin
        trace.push_back({bus.out_valid, bus.out_onehot});
        if (chk_en) begin
            if (!bus.in_ready) full_seen = 1'b1;
            check("onehot", 32'(bus.out_onehot), 32'(m_onehot));
            check("valid", 32'(bus.out_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(mq.size() != 0 || m_valid));
            check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
            check("popcnt_le1", 32'($countones(bus.out_onehot) <= 1), 32'd1);
`ifdef PRIODEC_EVENT_COUNT_EN
            check("event_cnt", 32'(event_cnt), 32'(m_evt));
`endif
        end
    end

    // Called right after a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [2:0] c, input logic n);
        bit acc;
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = c;
        bus.in_none  = n;
        forever begin
            acc = bus.in_ready;
            @(negedge clk);
            if (acc) break;
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout code=%0d", c);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_seq(input string nm, input logic [8:0] exp[$]);
        int st = -1;
        foreach (trace[i]) if (st < 0 && trace[i][8]) st = i;
        checks++;
        if (st < 0) begin
            errors++;
            $display("FAIL %s no strobe act=none exp=%0h", nm, exp[0]);
            return;
        end
        checks--;
        foreach (exp[k]) begin
            logic [8:0] a;
            a = (st + k < trace.size()) ? trace[st+k] : 9'h1ff;
            check(nm, 32'(a), 32'(exp[k]));
        end
    endtask

    task automatic check_vals(input string nm, input logic [7:0] exp[$]);
        logic [7:0] got[$];
        foreach (trace[i]) if (trace[i][8]) got.push_back(trace[i][7:0]);
        check({nm, "_len"}, 32'(got.size()), 32'(exp.size()));
        foreach (exp[k]) begin
            if (k < got.size()) check(nm, 32'(got[k]), 32'(exp[k]));
        end
    endtask

    initial begin
        logic [8:0]  es[$];
        logic [7:0]  ev[$];
        logic [15:0] evt0;
        int          nv;
        bus.in_valid = 1'b0;
        bus.in_code  = 3'd0;
        bus.in_none  = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_onehot", 32'(bus.out_onehot), 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(bus.in_ready), 32'h1);

        // Single code 5: hidden one cycle, then held two cycles.
        send(3'd5, 1'b0);
        check("t1_lat_valid", 32'(bus.out_valid), 32'h0);
        idle(1);
        check("t1_c1", 32'({bus.out_valid, bus.out_onehot}), 32'h120);
        idle(1);
        check("t1_c2", 32'({bus.out_valid, bus.out_onehot}), 32'h120);
        idle(1);
        check("t1_end", 32'({bus.out_valid, bus.out_onehot}), 32'h000);
        check("t1_busy", 32'(busy), 32'h0);

        // Back-to-back 0,7,2.
        idle(2);
        trace.delete();
        send(3'd0, 1'b0);
        send(3'd7, 1'b0);
        send(3'd2, 1'b0);
        idle(10);
        es = '{9'h101, 9'h101, 9'h180, 9'h180, 9'h104, 9'h104, 9'h000};
        check_seq("t2_seq", es);

        // Burst of eight to fill the FIFO.
        trace.delete();
        full_seen = 1'b0;
        for (int i = 0; i < 8; i++) send(3'(i), 1'b0);
        idle(25);
        check("t3_full_seen", 32'(full_seen), 32'h1);
        ev.delete();
        for (int i = 0; i < 8; i++) begin
            ev.push_back(8'(1 << i));
            ev.push_back(8'(1 << i));
        end
        check_vals("t3_vals", ev);

        // None marker followed by code 1.
        trace.delete();
`ifdef PRIODEC_EVENT_COUNT_EN
        evt0 = event_cnt;
`else
        evt0 = 16'h0;
`endif
        send(3'd3, 1'b1);
        send(3'd1, 1'b0);
        idle(8);
        es = '{9'h100, 9'h100, 9'h102, 9'h102, 9'h000};
        check_seq("t4_seq", es);
`ifdef PRIODEC_EVENT_COUNT_EN
        check("t4_evt_delta", 32'(event_cnt - evt0), 32'h1);
`else
        check("t4_evt_base", 32'(evt0 + 16'(bus.out_valid)), 32'h0);
`endif

        // Reset during second hold cycle with two entries queued.
        send(3'd6, 1'b0);
        send(3'd3, 1'b0);
        send(3'd4, 1'b0);
        check("t5_hold2", 32'({bus.out_valid, bus.out_onehot}), 32'h140);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t5_onehot", 32'(bus.out_onehot), 32'h0);
        check("t5_valid", 32'(bus.out_valid), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_ready", 32'(bus.in_ready), 32'h1);
        trace.delete();
        idle(8);
        nv = 0;
        foreach (trace[i]) if (trace[i][8]) nv++;
        check("t5_no_ghost", 32'(nv), 32'h0);

        // Sweep with random gaps.
        trace.delete();
        for (int c = 0; c < 8; c++) begin
            idle($urandom_range(0, 3));
            send(3'(c), 1'b0);
        end
        idle(30);
        ev.delete();
        for (int c = 0; c < 8; c++) begin
            ev.push_back(8'(1 << c));
            ev.push_back(8'(1 << c));
        end
        check_vals("t6_vals", ev);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/priority_decoder_stream.md
Name: priority_decoder_stream

Overview:
- Inverse of the team's 8:3 priority encoder: accepts 3-bit encoded indices over a valid/ready stream and regenerates registered one-hot strobes on an 8-bit bus.
- Each decoded strobe is held for a programmable number of cycles.
- Small input FIFO absorbs bursts.
- Sits on the downstream side of an encoded request link; drives one-hot enables or acknowledges back to 8 requesters.

Parameters:
- CODE_W, 3, encoded index width.
- OUT_W, 8, one-hot width; must equal 2**CODE_W.
- FIFO_DEPTH, 4, input buffer entries; power of two, at least 2.
- HOLD_CYCLES, 2, cycles each strobe stays asserted; at least 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  producer has a code
- in_ready  output  1  block can accept; equals !fifo_full
- in_code  input  CODE_W  index to decode
- in_none  input  1  "no request" marker; decodes to all-zero output
- out_onehot  output  OUT_W  registered one-hot strobe
- out_valid  output  1  high while a decoded entry (including none) is held
- busy  output  1  FIFO non-empty or state HOLD

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous and active-high on rst.
  - While rst=1 at a clk edge: FIFO pointers and count cleared, state IDLE, hold counter 0.
  - Reset values: out_onehot=0, out_valid=0, busy=0, in_ready=1 the cycle after reset.
  - Reset mid-hold aborts the strobe immediately; reset has priority over every other event.
- Push:
  - Occurs when in_valid && in_ready at a clk edge.
  - Stores {in_none, in_code}.
  - in_ready = (count != FIFO_DEPTH). No write-through when full, even if a pop occurs in the same cycle.
- State machine, states IDLE and HOLD:
  - IDLE: if the FIFO is non-empty, pop the head. out_onehot <= in_none ? 0 : (1 << code), out_valid <= 1, hold_cnt <= HOLD_CYCLES-1, go to HOLD.
  - HOLD with hold_cnt > 0: decrement; outputs stable.
  - HOLD with hold_cnt == 0 and FIFO non-empty: pop and load the next entry in the same edge. Back-to-back strobes have no gap cycle.
  - HOLD with hold_cnt == 0 and FIFO empty: out_onehot <= 0, out_valid <= 0, go to IDLE.
- Latency: a code pushed at edge N (FIFO previously empty, IDLE) appears on out_onehot after edge N+1 and is held for exactly HOLD_CYCLES cycles.
- Simultaneous push and pop: both take effect and count is unchanged. A pop from a FIFO that was empty before the edge never happens (no bypass).
- out_onehot always has at most one bit set. popcount(out_onehot) == 1 whenever out_valid=1 and the entry's none bit is 0.
- Pointer wrap-around: natural modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH+1).
- Hold counter width: $clog2(HOLD_CYCLES), minimum 1 bit.
- busy = (count != 0) || (state == HOLD).

Optional Feature:
- Macro: PRIODEC_EVENT_COUNT_EN.
- Defined:
  - Adds output event_cnt, 16 bits, reset to 0.
  - Increments on every pop whose none bit is 0.
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package priodec_pkg holds:
  - CODE_W / OUT_W defaults
  - state enum typedef (IDLE, HOLD)
  - entry typedef struct {none, code}
- One sub-module, priodec_fifo: synchronous FIFO, parameterised width/depth, with push, pop, full, empty and count outputs.
- The top module contains the state machine, hold counter and decode.

Test Plan:
- Reset, then push code 3'd5 once (HOLD_CYCLES=2) -> out_onehot=8'b0010_0000 with out_valid=1 for exactly 2 cycles starting the cycle after acceptance; then 0 and busy=0.
- Push 0,7,2 on consecutive cycles -> strobes 8'h01, 8'h80, 8'h04, each 2 cycles, no gap cycles, in order.
- Hold out_valid processing, push 5 entries (FIFO_DEPTH=4) -> in_ready=0 after the 4th accept; the 5th is accepted only after the first pop; no entry lost or duplicated.
- Push with in_none=1 then code 3'd1 -> out_valid=1 with out_onehot=0 for 2 cycles, then 8'h02 for 2 cycles. With PRIODEC_EVENT_COUNT_EN, event_cnt increments once.
- Assert rst during the second hold cycle of code 3'd6 with 2 entries queued -> next cycle out_onehot=0, out_valid=0, busy=0, in_ready=1; queued entries never appear.
- Sweep all 8 codes with random in_valid gaps -> scoreboard confirms out_onehot == 1<<code for each, popcount <= 1 every cycle.
